// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the instruction fetch slice:
//   NOP_INSTR        - canonical NOP (addi x0,x0,0) shown when fetch is empty
//   RESET_PC_DEFAULT - default PC of the first fetch after reset
//   fetch_entry_t    - one fetched instruction together with its PC
//   word_align()     - clears the two low address bits of a PC
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// ---------------------------------------------------------------------------
// fetch_buf
// Small FIFO of fetch_entry_t holding fetched instructions until decode
// consumes them. Push and pop in the same cycle are legal even when full
// (the popped slot is reused). flush empties the FIFO and wins over both.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   flush        - discard all entries
//   push         - write push_data at the tail
//   push_data    - entry to write
//   pop          - remove the head entry
//   head         - current head entry (meaningful when valid)
//   valid        - FIFO not empty
//   count        - number of stored entries (0..DEPTH)
// ---------------------------------------------------------------------------
module fetch_buf
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem_r [DEPTH];
    logic [AW-1:0]  rd_ptr_r;
    logic [AW-1:0]  wr_ptr_r;
    logic [AW:0]    count_r;
    logic           do_pop_s;
    logic           do_push_s;

    // Pop only a real entry; push at full only when the head leaves this cycle.
    always_comb begin
        do_pop_s  = pop && (count_r != {(AW+1){1'b0}});
        do_push_s = push && ((count_r != (AW+1)'(DEPTH)) || do_pop_s);
    end

    // Storage array: written at the tail on every accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '{pc: 32'h0000_0000, instr: NOP_INSTR};
            end
        end else if (do_push_s && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end else begin
            mem_r <= mem_r;
        end
    end

    // Pointers and occupancy; flush has priority over push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else if (flush) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1'b1);
                2'b01:   count_r <= count_r - (AW+1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign valid = (count_r != {(AW+1){1'b0}});
    assign count = count_r;

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: issues word-aligned requests to instruction
// memory, collects in-order responses into fetch_buf and presents the head
// entry to decode. A redirect (PCSrcE) flushes the buffer, restarts fetch at
// the aligned target and discards responses of requests already in flight.
// Optional feature macro: FETCH_PERF_EN adds perf_stall_cnt / perf_redir_cnt.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   StallF           - hold the head entry
//   PCSrcE,PCTargetE - redirect request and target
//   imem_req/addr    - fetch request and word-aligned address
//   imem_gnt         - request accepted this cycle
//   imem_rvalid/rdata- in-order response (at least one cycle after grant)
//   InstrF,PCF,PCPlus4F,ValidF - head of fetch buffer (NOP/0/0/0 when empty)
//   perf_stall_cnt   - (FETCH_PERF_EN) cycles with ValidF && StallF
//   perf_redir_cnt   - (FETCH_PERF_EN) cycles with PCSrcE
// ---------------------------------------------------------------------------
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallF,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        ValidF
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_redir_cnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          run_r;        // low only until the first edge after reset
    logic [31:0]   pc_r;         // next request address
    logic [31:0]   resp_pc_r;    // PC belonging to the next kept response
    logic [CW-1:0] in_flight_r;  // granted requests not yet answered
    logic [CW-1:0] drop_cnt_r;   // answers still to be discarded after redirect

    logic          imem_req_s;
    logic          grant_s;
    logic          drop_s;
    logic          push_s;
    logic          pop_s;
    logic          buf_valid_s;
    logic [CW-1:0] buf_count_s;
    fetch_entry_t  buf_head_s;
    fetch_entry_t  push_data_s;

    // Request only when every outstanding answer is guaranteed a buffer slot.
    always_comb begin
        if (run_r && !PCSrcE &&
            (({1'b0, in_flight_r} + {1'b0, buf_count_s}) < (CW+1)'(DEPTH))) begin
            imem_req_s = 1'b1;
        end else begin
            imem_req_s = 1'b0;
        end
        grant_s     = imem_req_s && imem_gnt;
        drop_s      = imem_rvalid && (drop_cnt_r != {CW{1'b0}});
        push_s      = imem_rvalid && !drop_s && !PCSrcE;
        pop_s       = buf_valid_s && !StallF;
        push_data_s = '{pc: resp_pc_r, instr: imem_rdata};
    end

    // Request/response bookkeeping; a redirect overrides all other updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_r       <= 1'b0;
            pc_r        <= RESET_PC;
            resp_pc_r   <= RESET_PC;
            in_flight_r <= {CW{1'b0}};
            drop_cnt_r  <= {CW{1'b0}};
        end else if (PCSrcE) begin
            run_r       <= 1'b1;
            pc_r        <= word_align(PCTargetE);
            resp_pc_r   <= word_align(PCTargetE);
            // No grant can happen while redirecting; any answer arriving now
            // is discarded, everything still outstanding must be dropped.
            in_flight_r <= in_flight_r - CW'(imem_rvalid);
            drop_cnt_r  <= in_flight_r - CW'(imem_rvalid);
        end else begin
            run_r <= 1'b1;
            if (grant_s) begin
                pc_r <= pc_r + 32'd4;
            end
            if (push_s) begin
                resp_pc_r <= resp_pc_r + 32'd4;
            end
            in_flight_r <= in_flight_r + CW'(grant_s) - CW'(imem_rvalid);
            if (drop_s) begin
                drop_cnt_r <= drop_cnt_r - CW'(1'b1);
            end
        end
    end

    fetch_buf #(
        .DEPTH (DEPTH)
    ) u_fetch_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (PCSrcE),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head      (buf_head_s),
        .valid     (buf_valid_s),
        .count     (buf_count_s)
    );

    // Decode-facing view of the buffer head with safe values when empty.
    always_comb begin
        if (buf_valid_s) begin
            InstrF   = buf_head_s.instr;
            PCF      = buf_head_s.pc;
            PCPlus4F = buf_head_s.pc + 32'd4;
        end else begin
            InstrF   = NOP_INSTR;
            PCF      = 32'h0000_0000;
            PCPlus4F = 32'h0000_0000;
        end
    end

    assign ValidF    = buf_valid_s;
    assign imem_req  = imem_req_s;
    assign imem_addr = pc_r;

`ifdef FETCH_PERF_EN
    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= 32'h0000_0000;
            perf_redir_cnt <= 32'h0000_0000;
        end else begin
            if (buf_valid_s && StallF) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (PCSrcE) begin
                perf_redir_cnt <= perf_redir_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
